// File: rtl/pixel_pkg.sv
// Pixel types and frame geometry shared by the stream FIFO and the packer stage.
package pixel_pkg;

  localparam int X_SIZE_DEFAULT = 640;
  localparam int Y_SIZE_DEFAULT = 480;
  localparam int PIXEL_W        = 26;

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Colour-only view of a pixel, used where sideband bits are irrelevant.
  function automatic logic [23:0] pixel_rgb(input pixel_t pix);
    return {pix.r, pix.g, pix.b};
  endfunction

endpackage

// File: rtl/pixel_line_checker.sv
// Input-side line integrity checker: tracks x position of accepted pixels,
// raises a sticky error on malformed lines and counts frames.
module pixel_line_checker #(
  parameter int X_SIZE = 640,
  parameter int FCNT_W = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              pix_accept,
  input  logic              pix_sof,
  input  logic              pix_eol,
  input  logic              clr_err,
  output logic              line_err,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int X_CNT_W = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam logic [X_CNT_W-1:0] X_LAST = X_CNT_W'(X_SIZE - 1);

  logic [X_CNT_W-1:0] x_cnt_r;
  logic [X_CNT_W-1:0] x_cur_s;
  logic [X_CNT_W-1:0] x_nxt_s;
  logic               err_s;
  logic               line_err_r;
  logic [FCNT_W-1:0]  frame_count_r;

  // A sof pixel always sits at x=0, whatever the counter held before it.
  always_comb begin
    x_cur_s = x_cnt_r;
    if (pix_sof) begin
      x_cur_s = {X_CNT_W{1'b0}};
    end else begin
      x_cur_s = x_cnt_r;
    end
  end

  // Classify the accepted pixel and pick the next x position.
  always_comb begin
    err_s   = 1'b0;
    x_nxt_s = x_cnt_r;
    if (pix_accept) begin
      if (pix_sof && (x_cnt_r != {X_CNT_W{1'b0}})) begin
        err_s = 1'b1;
      end else begin
        err_s = 1'b0;
      end
      if (pix_eol) begin
        if (x_cur_s != X_LAST) begin
          err_s = 1'b1;
        end else begin
          err_s = err_s;
        end
        x_nxt_s = {X_CNT_W{1'b0}};
      end else if (x_cur_s == X_LAST) begin
        err_s   = 1'b1;
        x_nxt_s = {X_CNT_W{1'b0}};
      end else begin
        x_nxt_s = x_cur_s + X_CNT_W'(1);
      end
    end else begin
      err_s   = 1'b0;
      x_nxt_s = x_cnt_r;
    end
  end

  // Position, sticky error (new error beats clear) and frame counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x_cnt_r       <= {X_CNT_W{1'b0}};
      line_err_r    <= 1'b0;
      frame_count_r <= {FCNT_W{1'b0}};
    end else begin
      x_cnt_r <= x_nxt_s;
      if (err_s) begin
        line_err_r <= 1'b1;
      end else if (clr_err) begin
        line_err_r <= 1'b0;
      end
      if (pix_accept && pix_sof) begin
        frame_count_r <= frame_count_r + FCNT_W'(1);
      end
    end
  end

  assign line_err    = line_err_r;
  assign frame_count = frame_count_r;

endmodule

// File: rtl/pixel_stream_fifo.sv
// Elastic pixel buffer between the ray tracer output and the pixel packer,
// with sof/eol sideband carried alongside colour and a line checker on input.
module pixel_stream_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int X_SIZE = X_SIZE_DEFAULT,
  parameter int FCNT_W = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [7:0]               in_r,
  input  logic [7:0]               in_g,
  input  logic [7:0]               in_b,
  input  logic                     in_sof,
  input  logic                     in_eol,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               out_r,
  output logic [7:0]               out_g,
  output logic [7:0]               out_b,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     line_err,
  input  logic                     clr_err,
  output logic [FCNT_W-1:0]        frame_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  pixel_t            mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [LVL_W-1:0]  level_nxt_s;
  logic              in_ready_s;
  logic              out_valid_s;
  logic              push_s;
  logic              pop_s;
  pixel_t            in_pix_s;
  pixel_t            head_s;

  // Handshake status comes only from the registered level, so a full FIFO
  // refuses a push even when the packer drains in the same cycle.
  assign in_ready_s  = (level_r != LVL_W'(DEPTH));
  assign out_valid_s = (level_r != {LVL_W{1'b0}});
  assign push_s      = in_valid & in_ready_s;
  assign pop_s       = out_valid_s & out_ready;

  assign in_pix_s = {in_sof, in_eol, in_r, in_g, in_b};
  assign head_s   = mem_r[rd_ptr_r];

  // Occupancy change for this cycle's push/pop combination.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers and level; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      level_r <= level_nxt_s;
    end
  end

  // Storage array; contents are meaningless while the slot is unoccupied.
  always_ff @(posedge aclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_pix_s;
    end
  end

  pixel_line_checker #(
    .X_SIZE (X_SIZE),
    .FCNT_W (FCNT_W)
  ) u_line_checker (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .pix_accept  (push_s),
    .pix_sof     (in_sof),
    .pix_eol     (in_eol),
    .clr_err     (clr_err),
    .line_err    (line_err),
    .frame_count (frame_count)
  );

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_sof   = head_s.sof;
  assign out_eol   = head_s.eol;
  assign out_r     = head_s.r;
  assign out_g     = head_s.g;
  assign out_b     = head_s.b;
  assign level     = level_r;

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Self-checking bench for pixel_stream_fifo with a queue-based reference model.
module tb_pixel_stream_fifo;

  localparam int DEPTH  = 16;
  localparam int XS     = 8;
  localparam int FCNT_W = 2;

  logic       aclk;
  logic       aresetn;
  logic [7:0] in_r, in_g, in_b;
  logic       in_sof, in_eol, in_valid, in_ready;
  logic [7:0] out_r, out_g, out_b;
  logic       out_sof, out_eol, out_valid, out_ready;
  logic [4:0] level;
  logic       line_err, clr_err;
  logic [1:0] frame_count;

  int errors = 0;
  int checks = 0;

  logic [25:0] q[$];
  int          m_x;
  bit          m_err;
  int          m_fc;

  pixel_stream_fifo #(.DEPTH(DEPTH), .X_SIZE(XS), .FCNT_W(FCNT_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_sof(in_sof), .in_eol(in_eol), .in_valid(in_valid), .in_ready(in_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_sof(out_sof), .out_eol(out_eol), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .line_err(line_err), .clr_err(clr_err), .frame_count(frame_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [25:0] out_entry();
    return {out_sof, out_eol, out_r, out_g, out_b};
  endfunction

  task automatic drive(input bit v, input bit s, input bit e, input logic [7:0] r,
                       input logic [7:0] g, input logic [7:0] b, input bit ordy, input bit clr);
    in_valid = v; in_sof = s; in_eol = e; in_r = r; in_g = g; in_b = b;
    out_ready = ordy; clr_err = clr;
  endtask

  task automatic model_reset();
    q.delete(); m_x = 0; m_err = 1'b0; m_fc = 0;
  endtask

  // Advance the reference model by one cycle from the inputs now applied, then clock.
  task automatic tick();
    bit push, pop, e_new;
    int x;
    logic [25:0] dropped;
    push  = in_valid && (q.size() < DEPTH);
    pop   = (q.size() != 0) && out_ready;
    e_new = 1'b0;
    if (push) begin
      x = in_sof ? 0 : m_x;
      if (in_sof && m_x != 0) e_new = 1'b1;
      if (in_eol) begin
        if (x != XS - 1) e_new = 1'b1;
        m_x = 0;
      end else if (x == XS - 1) begin
        e_new = 1'b1;
        m_x = 0;
      end else begin
        m_x = x + 1;
      end
      if (in_sof) m_fc = (m_fc + 1) % (1 << FCNT_W);
    end
    if (pop) dropped = q.pop_front();
    if (push) q.push_back({in_sof, in_eol, in_r, in_g, in_b});
    if (e_new) m_err = 1'b1;
    else if (clr_err) m_err = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 0, 0);
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL reset_line_err: got %0b expected 0", line_err); end
    checks++; if (frame_count !== 2'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
  endtask

  task automatic test_fill_drain();
    int exp_lvl;
    for (int i = 0; i < 20; i++) begin
      drive(1, i == 0, (i % 8) == 7, 8'(i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0);
      tick();
      exp_lvl = (i + 1 < DEPTH) ? i + 1 : DEPTH;
      checks++; if (level !== 5'(exp_lvl)) begin errors++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, level, exp_lvl); end
      checks++; if (in_ready !== (exp_lvl != DEPTH)) begin errors++; $display("FAIL fill_in_ready[%0d]: got %0b expected %0b", i, in_ready, exp_lvl != DEPTH); end
    end
    drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 0);
    for (int j = 0; j < DEPTH; j++) begin
      checks++; if (out_valid !== 1'b1 || out_r !== 8'(j)) begin errors++; $display("FAIL drain_data[%0d]: got valid=%0b r=%0d expected valid=1 r=%0d", j, out_valid, out_r, j); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid: got %0b expected 0", out_valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL drain_level: got %0d expected 0", level); end
    checks++; if (line_err !== m_err) begin errors++; $display("FAIL fill_line_err: got %0b expected %0b", line_err, m_err); end
  endtask

  task automatic test_concurrent();
    drive(1, 0, 0, 8'd0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0);
    tick();
    for (int k = 1; k <= 103; k++) begin
      drive(1, 0, (k % 8) == 7, 8'(k), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1, 0);
      checks++; if (level !== 5'd1 || out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL conc_flow[%0d]: got level=%0d valid=%0b ready=%0b expected 1/1/1", k, level, out_valid, in_ready); end
      checks++; if (out_r !== 8'(k - 1) || out_entry() !== q[0]) begin errors++; $display("FAIL conc_data[%0d]: got %07h expected %07h", k, out_entry(), q[0]); end
      tick();
    end
    drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 0);
    checks++; if (out_r !== 8'd103) begin errors++; $display("FAIL conc_last: got %0d expected 103", out_r); end
    tick();
    checks++; if (level !== 5'd0 || line_err !== 1'b0) begin errors++; $display("FAIL conc_end: got level=%0d err=%0b expected 0/0", level, line_err); end
  endtask

  task automatic test_clean_frame();
    int n, guard, f0;
    bit acc;
    logic [7:0] pr, pg, pb;
    f0 = m_fc; n = 0; guard = 0;
    pr = 8'($urandom_range(0, 255)); pg = 8'($urandom_range(0, 255)); pb = 8'($urandom_range(0, 255));
    while ((n < 3 * XS || q.size() != 0) && guard < 600) begin
      drive(n < 3 * XS, n == 0, (n % XS) == XS - 1, pr, pg, pb, 1'($urandom_range(0, 1)), 0);
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL clean_valid: got %0b expected %0b", out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if (out_entry() !== q[0]) begin errors++; $display("FAIL clean_data: got %07h expected %07h", out_entry(), q[0]); end
      end
      acc = (n < 3 * XS) && (q.size() < DEPTH);
      tick();
      if (acc) begin
        n++;
        pr = 8'($urandom_range(0, 255)); pg = 8'($urandom_range(0, 255)); pb = 8'($urandom_range(0, 255));
      end
      guard++;
    end
    checks++; if (guard >= 600) begin errors++; $display("FAIL clean_timeout: got %0d cycles expected fewer than 600", guard); end
    checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL clean_line_err: got %0b expected 0", line_err); end
    checks++; if (frame_count !== 2'((f0 + 1) % 4)) begin errors++; $display("FAIL clean_frame_count: got %0d expected %0d", frame_count, (f0 + 1) % 4); end
  endtask

  task automatic test_malformed();
    bit exp;
    for (int p = 1; p <= 6; p++) begin
      drive(1, p == 1, p == 6, 8'(p), 8'd0, 8'd0, 1, 0);
      tick();
      exp = (p == 6);
      checks++; if (line_err !== exp) begin errors++; $display("FAIL short_eol[%0d]: got %0b expected %0b", p, line_err, exp); end
    end
    drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 1);
    tick();
    checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL clr_err: got %0b expected 0", line_err); end
    for (int p = 1; p <= 9; p++) begin
      drive(1, 0, 0, 8'(p), 8'd0, 8'd0, 1, 0);
      tick();
      exp = (p >= 8);
      checks++; if (line_err !== exp) begin errors++; $display("FAIL long_line[%0d]: got %0b expected %0b", p, line_err, exp); end
    end
    drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 1);
    tick();
    drive(1, 1, 0, 8'hAA, 8'd0, 8'd0, 1, 1);
    tick();
    checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL clr_vs_err: got %0b expected 1", line_err); end
    checks++; if (frame_count !== 2'(m_fc)) begin errors++; $display("FAIL mal_frame_count: got %0d expected %0d", frame_count, m_fc); end
    drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 1);
    tick();
    for (int p = 1; p <= 7; p++) begin
      drive(1, 0, p == 7, 8'(p), 8'd0, 8'd0, 1, 0);
      tick();
      checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL realign[%0d]: got %0b expected 0", p, line_err); end
    end
    drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 0);
    tick();
  endtask

  task automatic test_frame_wrap();
    int seq [5] = '{1, 2, 3, 0, 1};
    apply_reset();
    for (int f = 0; f < 5; f++) begin
      for (int p = 0; p < XS; p++) begin
        drive(1, p == 0, p == XS - 1, 8'($urandom_range(0, 255)), 8'd0, 8'd0, 1, 0);
        tick();
      end
      checks++; if (frame_count !== 2'(seq[f])) begin errors++; $display("FAIL frame_wrap[%0d]: got %0d expected %0d", f, frame_count, seq[f]); end
    end
    checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL wrap_line_err: got %0b expected 0", line_err); end
    drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 0);
    tick();
  endtask

  task automatic test_reset_mid();
    for (int p = 0; p < 10; p++) begin
      drive(1, p == 0, p == XS - 1, 8'(p), 8'd0, 8'd0, 0, 0);
      tick();
    end
    checks++; if (level !== 5'd10) begin errors++; $display("FAIL pre_reset_level: got %0d expected 10", level); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || level !== 5'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_reset: got valid=%0b level=%0d ready=%0b expected 0/0/1", out_valid, level, in_ready); end
    drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 0, 0);
    model_reset();
    repeat (2) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    for (int p = 0; p < 2 * XS + 1; p++) begin
      if (p < 2 * XS) drive(1, p == 0, (p % XS) == XS - 1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'd0, 1, 0);
      else drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 0);
      if (q.size() != 0) begin
        checks++; if (out_valid !== 1'b1 || out_entry() !== q[0]) begin errors++; $display("FAIL post_reset_data[%0d]: got %07h expected %07h", p, out_entry(), q[0]); end
      end
      tick();
    end
    checks++; if (line_err !== 1'b0 || frame_count !== 2'd1 || level !== 5'd0) begin errors++; $display("FAIL post_reset_frame: got err=%0b fc=%0d level=%0d expected 0/1/0", line_err, frame_count, level); end
  endtask

  initial begin
    aresetn = 1'b0;
    drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 0, 0);
    model_reset();
    test_reset();
    test_fill_drain();
    test_concurrent();
    test_clean_frame();
    test_malformed();
    test_frame_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
